// File: rtl/shift_reg_in.sv
// shift_reg_in: reads one N-bit frame from a 74HC165 chain (parallel load, then MSB-first serial shift)
// ports: i_clk/i_rst clock and sync reset; i_Start frame request taken only in IDLE; i_SER_IN from QH;
//        o_Ready idle flag; o_Data last frame; o_Valid one-cycle update strobe; o_SH_LD/o_CLK drive the 165
module shift_reg_in #(
  parameter int N = 8,
  parameter int CLK_DIV = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_Start,
  input  logic         i_SER_IN,
  output logic         o_Ready,
  output logic [N-1:0] o_Data,
  output logic         o_Valid,
  output logic         o_SH_LD,
  output logic         o_CLK
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(N);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, HIGH, LOW, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [N-1:0] sr_q, sr_d, data_q, data_d, shifted;
  logic last;
  // bit_q holds the index of the next bit to sample in LOW; bit N-1 is taken at the end of SETTLE
  always_comb begin
    last = cnt_q == CW'(CLK_DIV - 1);
    shifted = {sr_q[N-2:0], i_SER_IN};
    state_d = state_q;
    bit_d = bit_q;
    sr_d = sr_q;
    data_d = data_q;
    cnt_d = (state_q == IDLE || state_q == DONE || last) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: state_d = i_Start ? LOAD : IDLE;
      LOAD: state_d = last ? SETTLE : LOAD;
      SETTLE: if (last) begin
        sr_d = shifted;
        bit_d = BW'(N - 2);
        state_d = HIGH;
      end
      HIGH: state_d = last ? LOW : HIGH;
      LOW: if (last) begin
        sr_d = shifted;
        bit_d = bit_q - 1'b1;
        state_d = bit_q == '0 ? DONE : HIGH;
        data_d = bit_q == '0 ? shifted : data_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      data_q <= data_d;
    end
  end
  assign o_Ready = state_q == IDLE;
  assign o_Valid = state_q == DONE;
  assign o_SH_LD = state_q != LOAD;
  assign o_CLK = state_q == HIGH;
  assign o_Data = data_q;
endmodule

// File: tb/tb_shift_reg_in.sv
// tb_shift_reg_in: directed checks of shift_reg_in against a behavioural 74HC165
module tb_shift_reg_in;
  logic clk = 1'b0, rst, start;
  logic ser_in, ready, valid, sh_ld, sclk;
  logic [7:0] data, par = 8'h00, sh = 8'h00;
  logic prev_sclk = 1'b0, prev_mon = 1'b0;
  int total = 0, bad = 0;
  int rises = 0, ld_low = 0, vcnt = 0, bad_hi = 0, overlap = 0, hi_len = 0;
  always #5 clk = ~clk;
  shift_reg_in #(.N(8), .CLK_DIV(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_Start(start), .i_SER_IN(ser_in),
    .o_Ready(ready), .o_Data(data), .o_Valid(valid), .o_SH_LD(sh_ld), .o_CLK(sclk)
  );
  always @(posedge clk) begin
    prev_sclk <= sclk;
    if (!sh_ld) sh <= par;
    else if (sclk && !prev_sclk) sh <= {sh[6:0], 1'b0};
  end
  assign ser_in = sh[7];
  always @(negedge clk) begin
    if (!sh_ld) ld_low++;
    if (sclk && !prev_mon) rises++;
    if (sclk && !sh_ld) overlap++;
    if (valid) vcnt++;
    if (!sclk && prev_mon && hi_len != 2) bad_hi++;
    hi_len = sclk ? hi_len + 1 : 0;
    prev_mon = sclk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic kick();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask
  task automatic run_frame(input logic [7:0] p, input bit pulse);
    int r0, l0, v0, h0, o0, lat;
    par = p;
    r0 = rises; l0 = ld_low; v0 = vcnt; h0 = bad_hi; o0 = overlap;
    kick();
    lat = 0;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      start = pulse && (lat == 1 || lat == 5);
    end
    start = 1'b0;
    chk("latency", lat, 32);
    chk("data", {24'h0, data}, {24'h0, p});
    @(posedge clk); #1;
    chk("valid_single", {31'h0, valid}, 0);
    chk("ready_after", {31'h0, ready}, 1);
    chk("ld_cycles", ld_low - l0, 2);
    chk("clk_rises", rises - r0, 7);
    chk("valid_cnt", vcnt - v0, 1);
    chk("high_len", bad_hi - h0, 0);
    chk("clk_during_ld", overlap - o0, 0);
  endtask
  initial begin
    int v, lat;
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sh_ld", {31'h0, sh_ld}, 1);
    chk("rst_clk", {31'h0, sclk}, 0);
    chk("rst_ready", {31'h0, ready}, 1);
    chk("rst_valid", {31'h0, valid}, 0);
    chk("rst_data", {24'h0, data}, 0);
    rst = 1'b0;
    run_frame(8'hA5, 1'b0);
    run_frame(8'h80, 1'b0);
    run_frame(8'h01, 1'b0);
    par = 8'h3C; v = vcnt;
    @(posedge clk); #1 start = 1'b1;
    lat = 0;
    while (!valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_lat1", lat, 33);
    chk("b2b_data1", {24'h0, data}, 32'h3C);
    par = 8'hC3;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        chk("b2b_gap_valid", {31'h0, valid}, 0);
        chk("b2b_gap_ready", {31'h0, ready}, 1);
      end
      if (lat == 2) chk("b2b_restart", {31'h0, ready}, 0);
    end while (!valid && lat < 200);
    chk("b2b_lat2", lat, 34);
    chk("b2b_data2", {24'h0, data}, 32'hC3);
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("b2b_valid_cnt", vcnt - v, 2);
    chk("b2b_idle", {31'h0, ready}, 1);
    run_frame(8'h96, 1'b1);
    v = vcnt;
    repeat (40) @(posedge clk);
    #1;
    chk("ignored_start", vcnt - v, 0);
    chk("ignored_idle", {31'h0, ready}, 1);
    par = 8'hFF;
    v = rises;
    kick();
    repeat (12) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_rises", rises - v, 3);
    chk("abort_sh_ld", {31'h0, sh_ld}, 1);
    chk("abort_clk", {31'h0, sclk}, 0);
    chk("abort_ready", {31'h0, ready}, 1);
    chk("abort_valid", {31'h0, valid}, 0);
    chk("abort_data", {24'h0, data}, 0);
    v = vcnt;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_no_valid", vcnt - v, 0);
    run_frame(8'h5A, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shift_reg_in.md
SHIFT_REG_IN -- requirements
Module: shift_reg_in

Interface
REQ-001 SHALL have parameter N, default 8: number of bits read per frame; legal range N >= 2.
REQ-002 SHALL have parameter CLK_DIV, default 2: length in i_clk cycles of each o_CLK phase and of the load pulse; legal range CLK_DIV >= 1.
REQ-003 SHALL have port i_clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_Start, input, 1 bit: frame request, sampled only while o_Ready=1.
REQ-006 SHALL have port i_SER_IN, input, 1 bit: serial data from the 74HC165 QH pin.
REQ-007 SHALL have port o_Ready, output, 1 bit: 1 exactly when the state is IDLE.
REQ-008 SHALL have port o_Data, output, N bits: last completed frame, MSB first.
REQ-009 SHALL have port o_Valid, output, 1 bit: one-cycle pulse, asserted when o_Data updates.
REQ-010 SHALL have port o_SH_LD, output, 1 bit: active-low parallel load to the 74HC165.
REQ-011 SHALL have port o_CLK, output, 1 bit: shift clock to the 74HC165.

Function
REQ-012 SHALL implement states IDLE, LOAD, SETTLE, HIGH, LOW and DONE; all outputs SHALL be registered or decoded from state only.
REQ-013 IDLE: o_SH_LD=1, o_CLK=0, o_Valid=0; on the edge E0 that sees i_Start=1, SHALL go to LOAD.
REQ-014 LOAD: o_SH_LD=0 for exactly CLK_DIV cycles, o_CLK=0; then SHALL go to SETTLE.
REQ-015 SETTLE: o_SH_LD=1, o_CLK=0 for CLK_DIV cycles; on its last edge SHALL sample i_SER_IN as bit N-1, then go to HIGH.
REQ-016 HIGH: o_CLK=1 for CLK_DIV cycles; then SHALL go to LOW.
REQ-017 LOW: o_CLK=0 for CLK_DIV cycles; on its last edge SHALL sample i_SER_IN as the next lower bit.
REQ-018 After LOW, SHALL go to HIGH if bits remain; after bit 0 is sampled, SHALL go to DONE.
REQ-019 Each frame SHALL contain exactly N-1 o_CLK rising edges; o_CLK SHALL never be 1 while o_SH_LD=0.
REQ-020 Sampled bits SHALL shift into an internal N-bit register MSB first; o_Data SHALL be loaded from it on the edge entering DONE.
REQ-021 DONE SHALL last exactly one cycle, with o_Valid=1 and o_Ready=0; then SHALL go to IDLE.
REQ-022 Timing: o_Valid SHALL be high from edge E0+2*CLK_DIV*N to E0+2*CLK_DIV*N+1; for N=8 and CLK_DIV=2, that is 32 edges after E0.
REQ-023 i_Start while not IDLE SHALL be ignored, not queued; if i_Start is held high, the next frame SHALL begin on the first IDLE edge, giving exactly one IDLE cycle between frames.
REQ-024 o_Data SHALL hold its value between DONE states, and SHALL hold unchanged through an in-progress frame.
REQ-025 Bit and phase counters SHALL be sized for N and CLK_DIV with no wrap-around in any legal configuration.

Reset
REQ-026 i_rst=1 at an edge SHALL force IDLE, o_SH_LD=1, o_CLK=0, o_Valid=0, o_Ready=1, o_Data=0, and clear all counters and the shift register; this has priority over all other inputs.
REQ-027 Reset mid-frame SHALL abort the frame with no o_Valid pulse; the first frame after reset SHALL be fully correct.

Verification
REQ-028 Hold i_rst for 3 cycles -> o_SH_LD=1, o_CLK=0, o_Ready=1, o_Valid=0, o_Data=8'h00.
REQ-029 Use a behavioural 74HC165 model with parallel 8'hA5, CLK_DIV=2; pulse i_Start -> o_SH_LD low for exactly 2 cycles, 7 o_CLK rises each high for 2 cycles, o_Valid high for 1 cycle 32 edges after E0, o_Data=8'hA5.
REQ-030 Parallel inputs 8'h80, then 8'h01 -> o_Data=8'h80, then 8'h01, confirming MSB-first order and both end bits.
REQ-031 Hold i_Start high while the model changes from 8'h3C to 8'hC3 between frames -> back-to-back frames with one IDLE cycle between, single-cycle o_Valid each, o_Data 8'h3C then 8'hC3.
REQ-032 Pulse i_Start during LOAD and during HIGH -> no extra frame and no extra o_Valid.
REQ-033 Assert i_rst after the 3rd o_CLK rise -> REQ-026 values on the next cycle and no o_Valid; a following i_Start with model 8'h5A -> o_Data=8'h5A.
